// File: rtl/fsb_pkg.sv
// Shared types and default timing for the fast-bus DRAM sequencer.
//   dram_st_t   : sequencer state
//   *_DEF       : default address width and DRAM timing, in FCLK cycles
//   max3        : helper used to size the shared timing counter
package fsb_pkg;

    localparam int ROW_W_DEF   = 10;
    localparam int CAS_CYC_DEF = 2;
    localparam int RAS_PRE_DEF = 2;
    localparam int REF_RAS_DEF = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ROW,
        ST_COL,
        ST_HOLD,
        ST_PRE,
        ST_RCAS,
        ST_RRAS
    } dram_st_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/fsb_dram_ctl.sv
// DRAM sequencer for one bank of 16-bit DRAM on the fast bus.
// Arbitrates CBR refresh against CPU RAM cycles and drives the muxed address and strobes.
// Ports:
//   FCLK, Reset           clock and synchronous active-high reset
//   nAS, ASActive,        CPU strobe and its FSB-qualified active/negated views
//   ASInactive
//   RAMCS, RnW, nUDS,     decoded RAM select, direction and byte strobes
//   nLDS
//   AddrRow, AddrCol      row/column halves of the CPU address
//   RefReq, RefUrgent     refresh owed / overdue, from FSB
//   RefAck                one-cycle pulse when a refresh is committed
//   Ready                 RAM data valid, held until AS negates
//   RA                    multiplexed DRAM address
//   nRAS, nCASH, nCASL,   DRAM strobes and write enable (all registered)
//   nDRAMWE
module fsb_dram_ctl
    import fsb_pkg::*;
#(
    parameter int ROW_W   = ROW_W_DEF,
    parameter int CAS_CYC = CAS_CYC_DEF,
    parameter int RAS_PRE = RAS_PRE_DEF,
    parameter int REF_RAS = REF_RAS_DEF
) (
    input  logic             FCLK,
    input  logic             Reset,
    input  logic             nAS,
    input  logic             ASActive,
    input  logic             ASInactive,
    input  logic             RAMCS,
    input  logic             RnW,
    input  logic             nUDS,
    input  logic             nLDS,
    input  logic [ROW_W-1:0] AddrRow,
    input  logic [ROW_W-1:0] AddrCol,
    input  logic             RefReq,
    input  logic             RefUrgent,
    output logic             RefAck,
    output logic             Ready,
    output logic [ROW_W-1:0] RA,
    output logic             nRAS,
    output logic             nCASH,
    output logic             nCASL,
    output logic             nDRAMWE
);

    localparam int CNT_W = $clog2(max3(CAS_CYC, RAS_PRE, REF_RAS)) + 1;
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] LD_CAS = CNT_W'(CAS_CYC);
    localparam logic [CNT_W-1:0] LD_PRE = CNT_W'(RAS_PRE);
    localparam logic [CNT_W-1:0] LD_RAS = CNT_W'(REF_RAS);

    dram_st_t         state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             start_acc;
    logic             cas_on;
    logic             ras_d, cash_d, casl_d, we_d, ready_d, ack_d;
    logic [ROW_W-1:0] ra_d;

    // nAS low qualifies ASActive so a stale FSB flag cannot start a cycle.
    assign start_acc = ASActive & RAMCS & ~nAS;
    // COL timing only advances once a byte strobe is actually on the DRAM pins.
    assign cas_on    = ~(nCASH & nCASL);

    // Reset lands in PRE so tRP holds even if it cuts an access short.
    always_ff @(posedge FCLK) begin
        if (Reset) begin
            state <= ST_PRE;
            cnt   <= LD_PRE;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    // One shared down-counter: COL CAS time, RRAS low time, PRE precharge.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        unique case (state)
            ST_IDLE: begin
                if (RefUrgent)      state_d = ST_RCAS;
                else if (start_acc) state_d = ST_ROW;
                else if (RefReq)    state_d = ST_RCAS;
            end
            ST_ROW: begin
                if (ASInactive) begin
                    state_d = ST_PRE;
                    cnt_d   = LD_PRE;
                end else begin
                    state_d = ST_COL;
                    cnt_d   = LD_CAS;
                end
            end
            ST_COL: begin
                // Abort takes priority over a count that completes the same cycle.
                if (ASInactive) begin
                    state_d = ST_PRE;
                    cnt_d   = LD_PRE;
                end else if (cas_on) begin
                    if (cnt <= ONE) state_d = ST_HOLD;
                    else            cnt_d   = cnt - ONE;
                end
            end
            ST_HOLD: begin
                if (ASInactive) begin
                    state_d = ST_PRE;
                    cnt_d   = LD_PRE;
                end
            end
            ST_PRE: begin
                if (cnt <= ONE) state_d = ST_IDLE;
                else            cnt_d   = cnt - ONE;
            end
            ST_RCAS: begin
                state_d = ST_RRAS;
                cnt_d   = LD_RAS;
            end
            ST_RRAS: begin
                if (cnt <= ONE) begin
                    state_d = ST_PRE;
                    cnt_d   = LD_PRE;
                end else begin
                    cnt_d = cnt - ONE;
                end
            end
            default: begin
                state_d = ST_PRE;
                cnt_d   = LD_PRE;
            end
        endcase
    end

    // Output values are decoded from the state being entered, then registered,
    // so pins change on the same edge as the state.
    always_comb begin
        ras_d   = nRAS;
        cash_d  = nCASH;
        casl_d  = nCASL;
        we_d    = nDRAMWE;
        ra_d    = RA;
        ready_d = 1'b0;
        ack_d   = 1'b0;
        unique case (state_d)
            ST_IDLE: begin
                ras_d  = 1'b1;
                cash_d = 1'b1;
                casl_d = 1'b1;
                we_d   = 1'b1;
                ra_d   = AddrRow;
            end
            ST_ROW: begin
                ras_d  = 1'b0;
                cash_d = 1'b1;
                casl_d = 1'b1;
                we_d   = RnW;
                ra_d   = AddrRow;
            end
            ST_COL: begin
                ras_d  = 1'b0;
                cash_d = nUDS;
                casl_d = nLDS;
                ra_d   = AddrCol;
            end
            ST_HOLD: begin
                ras_d   = 1'b0;
                ra_d    = AddrCol;
                ready_d = 1'b1;
            end
            ST_RCAS: begin
                ras_d  = 1'b1;
                cash_d = 1'b0;
                casl_d = 1'b0;
                we_d   = 1'b1;
                ack_d  = 1'b1;
            end
            ST_RRAS: begin
                ras_d  = 1'b0;
                cash_d = 1'b0;
                casl_d = 1'b0;
            end
            default: begin
                ras_d  = 1'b1;
                cash_d = 1'b1;
                casl_d = 1'b1;
                we_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge FCLK) begin
        if (Reset) begin
            nRAS    <= 1'b1;
            nCASH   <= 1'b1;
            nCASL   <= 1'b1;
            nDRAMWE <= 1'b1;
            Ready   <= 1'b0;
            RefAck  <= 1'b0;
            RA      <= '0;
        end else begin
            nRAS    <= ras_d;
            nCASH   <= cash_d;
            nCASL   <= casl_d;
            nDRAMWE <= we_d;
            Ready   <= ready_d;
            RefAck  <= ack_d;
            RA      <= ra_d;
        end
    end

endmodule

// File: tb/tb_fsb_dram_ctl.sv
// Self-checking bench for fsb_dram_ctl. Expected pin activity for each transaction
// is computed as cycle windows (row cycle, first CAS cycle, Ready cycle, refresh slot)
// from the sequencing rules, then compared every cycle.
module tb_fsb_dram_ctl;

    localparam int ROW_W   = 10;
    localparam int CAS_CYC = 2;
    localparam int RAS_PRE = 2;
    localparam int REF_RAS = 3;

    logic             FCLK = 1'b0;
    logic             Reset;
    logic             nAS, ASActive, ASInactive, RAMCS, RnW, nUDS, nLDS;
    logic [ROW_W-1:0] AddrRow, AddrCol, RA;
    logic             RefReq, RefUrgent, RefAck, Ready;
    logic             nRAS, nCASH, nCASL, nDRAMWE;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    fsb_dram_ctl #(
        .ROW_W  (ROW_W),
        .CAS_CYC(CAS_CYC),
        .RAS_PRE(RAS_PRE),
        .REF_RAS(REF_RAS)
    ) dut (
        .FCLK      (FCLK),
        .Reset     (Reset),
        .nAS       (nAS),
        .ASActive  (ASActive),
        .ASInactive(ASInactive),
        .RAMCS     (RAMCS),
        .RnW       (RnW),
        .nUDS      (nUDS),
        .nLDS      (nLDS),
        .AddrRow   (AddrRow),
        .AddrCol   (AddrCol),
        .RefReq    (RefReq),
        .RefUrgent (RefUrgent),
        .RefAck    (RefAck),
        .Ready     (Ready),
        .RA        (RA),
        .nRAS      (nRAS),
        .nCASH     (nCASH),
        .nCASL     (nCASL),
        .nDRAMWE   (nDRAMWE)
    );

    always #5 FCLK = ~FCLK;

    task automatic tick;
        @(posedge FCLK);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic set_idle;
        ASActive   = 1'b0;
        nAS        = 1'b1;
        ASInactive = 1'b1;
        RAMCS      = 1'b0;
        RnW        = 1'b1;
        nUDS       = 1'b1;
        nLDS       = 1'b1;
        RefReq     = 1'b0;
        RefUrgent  = 1'b0;
    endtask

    // One transaction starting with the DUT idle. rk: 0 none, 1 RefReq, 2 RefUrgent,
    // all raised in cycle 0 alongside the access (if hacc). dsa: cycle the data
    // strobes assert. abrt >= 0 negates AS abrt cycles after the row cycle.
    task automatic run_txn(input bit hacc, input int rk, input bit rnw, input bit uu,
                           input bit ul, input int dsa, input int hold, input int abrt,
                           input logic [ROW_W-1:0] row, input logic [ROW_W-1:0] col);
        int tr, cf, q, rs, last, endc, k;
        bit acc_on, in_acc, in_rc, in_rr, cas_acc;
        rs = -1000;
        tr = 1;
        if (rk == 2) begin
            rs = 1;
            // RCAS, REF_RAS low cycles, precharge, one idle arbitration cycle
            tr = rs + REF_RAS + RAS_PRE + 2;
        end
        cf = ((tr > dsa) ? tr : dsa) + 1;
        if (abrt >= 0) q = tr + abrt;
        else           q = cf + CAS_CYC + hold;
        if (rk == 1) rs = hacc ? (q + RAS_PRE + 2) : 1;
        last = hacc ? q : 0;
        if (rk != 0 && rs + REF_RAS > last) last = rs + REF_RAS;
        endc = last + RAS_PRE + 1;

        for (int c = 0; c < endc; c++) begin
            acc_on     = hacc && (c < q);
            ASActive   = acc_on;
            nAS        = !acc_on;
            ASInactive = !acc_on;
            RAMCS      = acc_on;
            RnW        = hacc ? rnw : 1'b1;
            nUDS       = !(acc_on && uu && c >= dsa);
            nLDS       = !(acc_on && ul && c >= dsa);
            AddrRow    = row;
            AddrCol    = col;
            RefUrgent  = (rk == 2) && (c < rs);
            RefReq     = (rk == 1) && (c < rs);
            tick;
            k       = c + 1;
            in_acc  = hacc && k >= tr && k <= q;
            cas_acc = hacc && k >= cf && k <= q;
            in_rc   = (rk != 0) && k >= rs && k <= rs + REF_RAS;
            in_rr   = (rk != 0) && k >= rs + 1 && k <= rs + REF_RAS;
            chk("nRAS",    32'(nRAS),    32'(!(in_acc || in_rr)));
            chk("nCASH",   32'(nCASH),   32'(!((cas_acc && uu) || in_rc)));
            chk("nCASL",   32'(nCASL),   32'(!((cas_acc && ul) || in_rc)));
            chk("nDRAMWE", 32'(nDRAMWE), 32'(!(in_acc && !rnw)));
            chk("Ready",   32'(Ready),   32'(hacc && k >= cf + CAS_CYC && k <= q));
            chk("RefAck",  32'(RefAck),  32'((rk != 0) && k == rs));
            if (in_acc) chk("RA", 32'(RA), (k == tr) ? 32'(row) : 32'(col));
        end
        set_idle;
    endtask

    initial begin
        set_idle;
        AddrRow = '0;
        AddrCol = '0;
        Reset   = 1'b1;
        tick;
        chk("rst_nRAS",    32'(nRAS),    32'(1));
        chk("rst_nCASH",   32'(nCASH),   32'(1));
        chk("rst_nCASL",   32'(nCASL),   32'(1));
        chk("rst_nDRAMWE", 32'(nDRAMWE), 32'(1));
        chk("rst_Ready",   32'(Ready),   32'(0));
        chk("rst_RefAck",  32'(RefAck),  32'(0));
        chk("rst_RA",      32'(RA),      32'(0));
        tick;
        Reset = 1'b0;
        repeat (RAS_PRE + 1) tick;

        // read, both bytes
        run_txn(1'b1, 0, 1'b1, 1'b1, 1'b1, 0, 1, -1, 10'h155, 10'h2AA);
        // write with late lower strobe only
        run_txn(1'b1, 0, 1'b0, 1'b0, 1'b1, 2, 0, -1, 10'h0A5, 10'h35A);
        // RefReq with access: access first
        run_txn(1'b1, 1, 1'b1, 1'b1, 1'b1, 0, 0, -1, 10'h3C3, 10'h03C);
        // RefUrgent with access: refresh first
        run_txn(1'b1, 2, 1'b1, 1'b1, 1'b1, 0, 0, -1, 10'h111, 10'h222);
        // abort in COL after one CAS cycle, abort in ROW
        run_txn(1'b1, 0, 1'b1, 1'b1, 1'b1, 0, 0, 1, 10'h2F0, 10'h10F);
        run_txn(1'b1, 0, 1'b0, 1'b1, 1'b0, 0, 0, 0, 10'h001, 10'h3FE);
        // refresh alone
        run_txn(1'b0, 1, 1'b1, 1'b1, 1'b1, 0, 0, -1, 10'h000, 10'h000);
        run_txn(1'b0, 2, 1'b1, 1'b1, 1'b1, 0, 0, -1, 10'h3FF, 10'h3FF);

        for (int i = 0; i < 24; i++) begin
            int rk, m, ab;
            bit hacc;
            rk   = int'($urandom_range(0, 2));
            hacc = (rk == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            m    = int'($urandom_range(1, 3));
            if ($urandom_range(0, 4) == 0) ab = int'($urandom_range(0, 2));
            else                           ab = -1;
            run_txn(hacc, rk, 1'($urandom_range(0, 1)), m[1], m[0],
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), ab,
                    10'($urandom), 10'($urandom));
        end

        // reset in the middle of a held read
        AddrRow    = 10'h0F0;
        AddrCol    = 10'h30F;
        RnW        = 1'b1;
        ASActive   = 1'b1;
        nAS        = 1'b0;
        ASInactive = 1'b0;
        RAMCS      = 1'b1;
        nUDS       = 1'b0;
        nLDS       = 1'b0;
        repeat (4) tick;
        chk("hold_Ready", 32'(Ready), 32'(1));
        Reset = 1'b1;
        tick;
        chk("mid_nRAS",  32'(nRAS),  32'(1));
        chk("mid_nCASH", 32'(nCASH), 32'(1));
        chk("mid_nCASL", 32'(nCASL), 32'(1));
        chk("mid_Ready", 32'(Ready), 32'(0));
        chk("mid_RA",    32'(RA),    32'(0));
        Reset = 1'b0;
        for (int j = 1; j <= RAS_PRE + 1; j++) begin
            tick;
            chk("trp_nRAS", 32'(nRAS), 32'(j <= RAS_PRE));
        end
        chk("trp_RA", 32'(RA), 32'(10'h0F0));
        set_idle;
        tick;
        chk("abort_nRAS",  32'(nRAS),  32'(1));
        chk("abort_nCASH", 32'(nCASH), 32'(1));
        chk("abort_Ready", 32'(Ready), 32'(0));
        repeat (RAS_PRE + 1) tick;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
